// File: rtl/dma_io_peripheral.sv
// dma_io_peripheral
// Device end of an 8237A-5 style DREQ/DACK handshake for one DMA channel.
// Device data is buffered in a small FIFO. In source mode (DIR=0) the FIFO
// is filled from the local stream and drained by DACK-qualified IOR_N
// cycles. In sink mode (DIR=1) it is filled by IOW_N cycles and drained to
// the local stream. A bus transfer completes on the strobe's rising edge,
// using a registered "strobe was low" qualifier so that DACK may fall in
// the same cycle.
module dma_io_peripheral #(
  parameter int CHANNEL = 0,
  parameter int DEPTH   = 8
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic        DIR,
  input  logic [3:0]  DACK,
  input  logic        IOR_N,
  input  logic        IOW_N,
  input  logic        EOP_N,
  input  logic [7:0]  DATA_IN,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_OE,
  output logic        DREQ,
  input  logic        DEV_IN_VALID,
  output logic        DEV_IN_READY,
  input  logic [7:0]  DEV_IN_DATA,
  output logic        DEV_OUT_VALID,
  input  logic        DEV_OUT_READY,
  output logic [7:0]  DEV_OUT_DATA,
  output logic        DONE,
  output logic        OVERRUN,
  output logic        UNDERRUN,
  output logic [15:0] XFER_COUNT
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic            enable_d_r;
  logic            dir_r;
  logic            dir_nx_s;
  logic [7:0]      mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nx_s;
  logic            rd_pend_r;
  logic            wr_pend_r;
  logic [7:0]      wr_data_r;
  logic            dreq_r;
  logic            dreq_nx_s;
  logic            done_r;
  logic            overrun_r;
  logic            underrun_r;
  logic [15:0]     xfer_r;

  logic            ack_s;
  logic            enable_rise_s;
  logic            armed_s;
  logic            empty_s;
  logic            full_s;
  logic            rd_low_s;
  logic            wr_low_s;
  logic            rd_done_s;
  logic            wr_done_s;
  logic            dev_in_ready_s;
  logic            dev_out_valid_s;
  logic            push_s;
  logic            pop_s;
  logic [7:0]      push_data_s;
  logic [7:0]      head_s;

  // Select this channel's acknowledge bit out of the DACK bus.
  always_comb begin
    ack_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == CHANNEL) begin
        ack_s = ack_s | DACK[i];
      end else begin
        ack_s = ack_s;
      end
    end
  end

  // Bus strobe qualification, completion detection and FIFO push/pop control.
  always_comb begin
    enable_rise_s   = ENABLE & ~enable_d_r;
    armed_s         = (state_r == S_ARMED) || (state_r == S_ACTIVE);
    empty_s         = (count_r == {CW{1'b0}});
    full_s          = (count_r == DEPTH_C);
    head_s          = mem_r[rd_ptr_r];
    rd_low_s        = armed_s & ack_s & ~IOR_N & ~dir_r;
    wr_low_s        = armed_s & ack_s & ~IOW_N & dir_r;
    rd_done_s       = rd_pend_r & IOR_N;
    wr_done_s       = wr_pend_r & IOW_N;
    dev_in_ready_s  = armed_s & ~dir_r & ~full_s;
    dev_out_valid_s = dir_r & ~empty_s;
    push_s          = (DEV_IN_VALID & dev_in_ready_s) | (wr_done_s & ~full_s);
    pop_s           = (DEV_OUT_READY & dev_out_valid_s) | (rd_done_s & ~empty_s);
    push_data_s     = dir_r ? wr_data_r : DEV_IN_DATA;
  end

  // Next FIFO occupancy; an arm flushes, simultaneous push and pop cancel.
  always_comb begin
    count_nx_s = count_r;
    if (enable_rise_s) begin
      count_nx_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nx_s = count_r + CNT_ONE;
        2'b01:   count_nx_s = count_r - CNT_ONE;
        default: count_nx_s = count_r;
      endcase
    end
  end

  // Next state of the block sequencer; ENABLE low always wins.
  always_comb begin
    state_nx_s = state_r;
    if (!ENABLE) begin
      state_nx_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (enable_rise_s) state_nx_s = S_ARMED;
          else               state_nx_s = S_IDLE;
        end
        S_ARMED: begin
          if (!EOP_N)     state_nx_s = S_DONE;
          else if (ack_s) state_nx_s = S_ACTIVE;
          else            state_nx_s = S_ARMED;
        end
        S_ACTIVE: begin
          if (!EOP_N)      state_nx_s = S_DONE;
          else if (!ack_s) state_nx_s = S_ARMED;
          else             state_nx_s = S_ACTIVE;
        end
        S_DONE:  state_nx_s = S_DONE;
        default: state_nx_s = S_IDLE;
      endcase
    end
  end

  // DREQ is registered from next state and next occupancy so it drops one cycle after EOP or empty/full.
  always_comb begin
    dir_nx_s  = enable_rise_s ? DIR : dir_r;
    dreq_nx_s = 1'b0;
    if ((state_nx_s == S_ARMED) || (state_nx_s == S_ACTIVE)) begin
      if (dir_nx_s) dreq_nx_s = (count_nx_s < DEPTH_C);
      else          dreq_nx_s = (count_nx_s != {CW{1'b0}});
    end else begin
      dreq_nx_s = 1'b0;
    end
  end

  // DATABUS drive while this channel's read strobe is active; FF when nothing is buffered.
  always_comb begin
    DATA_OE  = 1'b0;
    DATA_OUT = 8'h00;
    if (rd_low_s) begin
      DATA_OE  = 1'b1;
      DATA_OUT = empty_s ? 8'hFF : head_s;
    end else begin
      DATA_OE  = 1'b0;
      DATA_OUT = 8'h00;
    end
  end

  // Sequencer state, arm edge detector and latched direction.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= S_IDLE;
      enable_d_r <= 1'b0;
      dir_r      <= 1'b0;
      dreq_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      enable_d_r <= ENABLE;
      dir_r      <= dir_nx_s;
      dreq_r     <= dreq_nx_s;
    end
  end

  // Strobe-low qualifiers and the sink data capture from the last low cycle.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_pend_r <= 1'b0;
      wr_pend_r <= 1'b0;
      wr_data_r <= 8'h00;
    end else if (enable_rise_s) begin
      rd_pend_r <= 1'b0;
      wr_pend_r <= 1'b0;
      wr_data_r <= wr_data_r;
    end else begin
      rd_pend_r <= rd_low_s ? 1'b1 : (IOR_N ? 1'b0 : rd_pend_r);
      wr_pend_r <= wr_low_s ? 1'b1 : (IOW_N ? 1'b0 : wr_pend_r);
      wr_data_r <= wr_low_s ? DATA_IN : wr_data_r;
    end
  end

  // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (enable_rise_s) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nx_s;
    end
  end

  // Sticky status flags and the transfer counter, all cleared by a new arm.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
      xfer_r     <= 16'h0000;
    end else if (enable_rise_s) begin
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
      xfer_r     <= 16'h0000;
    end else begin
      if (armed_s && (state_nx_s == S_DONE)) done_r <= 1'b1;
      if (rd_done_s && empty_s)               underrun_r <= 1'b1;
      if (wr_done_s && full_s)                overrun_r  <= 1'b1;
      if (rd_done_s || wr_done_s)             xfer_r     <= xfer_r + 16'h0001;
    end
  end

  assign DREQ          = dreq_r;
  assign DEV_IN_READY  = dev_in_ready_s;
  assign DEV_OUT_VALID = dev_out_valid_s;
  assign DEV_OUT_DATA  = empty_s ? 8'h00 : head_s;
  assign DONE          = done_r;
  assign OVERRUN       = overrun_r;
  assign UNDERRUN      = underrun_r;
  assign XFER_COUNT    = xfer_r;

endmodule
